// File: rtl/dtcm_dma_engine.sv
// Purpose: DMA initiator on the DTCM DMA port; forward word-by-word block copy (read src word, write to dst).
// Latency: first read the cycle after start; 3 cycles per word with no stalls; done pulse 3*len+1 cycles after start.
// Backpressure: request outputs hold stable while dma_dtcm_ready is low; a read with no valid data times out into sts_err.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   cfg_start/abort/src/dst/len     single-cycle command from control logic
//   sts_busy/done/err/remaining     status back to control logic
//   dma_dtcm_*                      requester side of the DTCM DMA port
module dtcm_dma_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 13,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_src_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic                  sts_err,
  output logic [LEN_WIDTH-1:0]  sts_remaining,
  output logic                  dma_dtcm_access,
  input  logic                  dma_dtcm_ready,
  output logic                  dma_dtcm_rd0_wr1,
  output logic [ADDR_WIDTH-1:0] dma_dtcm_addr,
  output logic [DATA_WIDTH-1:0] dma_dtcm_wdata,
  input  logic [DATA_WIDTH-1:0] dma_dtcm_rdata,
  input  logic                  dma_dtcm_rdata_valid
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  // Word-align mask; applying it to the whole address keeps every input bit in use.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR, S_DONE} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q, addr_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [TW-1:0]         timer_q;
  logic                  busy_q, done_q, err_q, access_q, rw_q;

  logic [ADDR_WIDTH-1:0] src_d, dst_d;
  logic [LEN_WIDTH-1:0]  rem_d;

  // Post-write pointer/count values; addresses wrap naturally at 2^ADDR_WIDTH.
  assign src_d = src_q + ADDR_WIDTH'(4);
  assign dst_d = dst_q + ADDR_WIDTH'(4);
  assign rem_d = rem_q - LEN_WIDTH'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      addr_q   <= '0;
      buf_q    <= '0;
      rem_q    <= '0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      access_q <= 1'b0;
      rw_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE && cfg_abort) begin
        // A write accepted in the abort cycle has already happened on the bus, so account for it.
        if (state_q == S_WR && dma_dtcm_ready) begin
          src_q <= src_d;
          dst_q <= dst_d;
          rem_q <= rem_d;
        end
        state_q  <= S_IDLE;
        busy_q   <= 1'b0;
        access_q <= 1'b0;
        rw_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // Abort in IDLE only matters here: it suppresses a simultaneous start.
            if (cfg_start && !cfg_abort) begin
              src_q  <= cfg_src_addr & ALIGN_MASK;
              dst_q  <= cfg_dst_addr & ALIGN_MASK;
              rem_q  <= cfg_len;
              err_q  <= 1'b0;
              busy_q <= 1'b1;
              if (cfg_len == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q  <= S_RD_REQ;
                access_q <= 1'b1;
                rw_q     <= 1'b0;
                addr_q   <= cfg_src_addr & ALIGN_MASK;
              end
            end
          end
          S_RD_REQ: begin
            if (dma_dtcm_ready) begin
              state_q  <= S_RD_WAIT;
              access_q <= 1'b0;
              timer_q  <= '0;
            end
          end
          S_RD_WAIT: begin
            if (dma_dtcm_rdata_valid) begin
              buf_q    <= dma_dtcm_rdata;
              state_q  <= S_WR;
              access_q <= 1'b1;
              rw_q     <= 1'b1;
              addr_q   <= dst_q;
            end else if (timer_q == TMAX) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_WR: begin
            if (dma_dtcm_ready) begin
              src_q <= src_d;
              dst_q <= dst_d;
              rem_q <= rem_d;
              rw_q  <= 1'b0;
              if (rem_q == LEN_WIDTH'(1)) begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                access_q <= 1'b0;
              end else begin
                // Go straight into the next read request without dropping access.
                state_q  <= S_RD_REQ;
                access_q <= 1'b1;
                addr_q   <= src_d;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            access_q <= 1'b0;
            rw_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sts_busy         = busy_q;
  assign sts_done         = done_q;
  assign sts_err          = err_q;
  assign sts_remaining    = rem_q;
  assign dma_dtcm_access  = access_q;
  assign dma_dtcm_rd0_wr1 = rw_q;
  assign dma_dtcm_addr    = addr_q;
  assign dma_dtcm_wdata   = buf_q;

endmodule

// File: tb/tb_dtcm_dma_engine.sv
// Purpose: self-checking bench for dtcm_dma_engine with a small DTCM responder model.
// Latency: responder accepts per the stall limits and returns read data one cycle after an accepted read.
// Backpressure: ready is withheld for a programmed number of read/write cycles when requested.
module tb_dtcm_dma_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 13;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [AW-1:0] cfg_src_addr = '0;
  logic [AW-1:0] cfg_dst_addr = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          sts_busy, sts_done, sts_err;
  logic [LW-1:0] sts_remaining;
  logic          acc, rw, ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          rvalid = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dtcm_dma_engine dut (
    .clk(clk), .rstn(rstn),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr), .cfg_len(cfg_len),
    .sts_busy(sts_busy), .sts_done(sts_done), .sts_err(sts_err), .sts_remaining(sts_remaining),
    .dma_dtcm_access(acc), .dma_dtcm_ready(ready), .dma_dtcm_rd0_wr1(rw),
    .dma_dtcm_addr(addr), .dma_dtcm_wdata(wdata),
    .dma_dtcm_rdata(rdata), .dma_dtcm_rdata_valid(rvalid)
  );

  // ---------------- DTCM responder model ----------------
  logic [DW-1:0] mem [0:1023];
  int            rd_stall_seen = 0, wr_stall_seen = 0;
  int            rd_stall_lim = 0, wr_stall_lim = 0;
  logic          suppress_vld = 1'b0;
  logic          pl_vld = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat = '0;

  assign ready = !(acc && ((!rw && rd_stall_seen < rd_stall_lim) ||
                           ( rw && wr_stall_seen < wr_stall_lim)));

  always @(posedge clk) begin
    rvalid <= 1'b0;
    if (pl_vld) mem[pl_addr[11:2]] = pl_dat;
    if (acc && ready) begin
      if (rw) mem[addr[11:2]] = wdata;
      else begin
        rdata  <= mem[addr[11:2]];
        rvalid <= !suppress_vld;
      end
    end
    if (acc && !ready) begin
      if (rw) wr_stall_seen++;
      else    rd_stall_seen++;
    end
  end

  // ---------------- Monitor (samples on falling edge) ----------------
  int            cyc = 0;
  int            done_cnt = 0, busy_cnt = 0, acc_cnt = 0, inv_err = 0, stab_err = 0, done_cyc = 0;
  logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0, prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;
  logic          prev_stall = 1'b0, prev_rw = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sts_done) begin done_cnt++; done_cyc = cyc; end
    if (sts_busy) busy_cnt++;
    if (acc) begin
      acc_cnt++;
      if (rw) last_wr_addr = addr;
      else    last_rd_addr = addr;
    end
    if (!acc && rw) inv_err++;
    if (prev_stall && (!acc || addr !== prev_addr || rw !== prev_rw || (rw && wdata !== prev_wdata)))
      stab_err++;
    prev_stall = acc && !ready;
    prev_addr  = addr;
    prev_rw    = rw;
    prev_wdata = wdata;
  end

  function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_dat = d; pl_vld = 1'b1;
    @(posedge clk); #1;
    pl_vld = 1'b0;
  endtask

  // Snapshots taken at each start so checks use per-transfer deltas.
  int t0, d0, b0, a0, ie0, se0;

  task automatic start_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] l);
    cfg_src_addr = s; cfg_dst_addr = d; cfg_len = l; cfg_start = 1'b1;
    d0 = done_cnt; b0 = busy_cnt; a0 = acc_cnt; ie0 = inv_err; se0 = stab_err;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (sts_busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (sts_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, sts_busy, n);
    end
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset;
    #2;
    n_checks++;
    if ({sts_busy, sts_done, sts_err, acc, rw} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/err/acc/rw=%b required 00000", {sts_busy, sts_done, sts_err, acc, rw});
    end
    n_checks++;
    if (sts_remaining !== '0) begin n_fail++; $display("FAIL reset_remaining: got %0d required 0", sts_remaining); end
    n_checks++;
    if (addr !== '0 || wdata !== '0) begin
      n_fail++; $display("FAIL reset_bus: addr=%h wdata=%h required 0/0", addr, wdata);
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_copy;
    logic [DW-1:0] exp_w [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      poke(AW'(32'h100 + 4*i), exp_w[i]);
      poke(AW'(32'h200 + 4*i), 32'h0);
    end
    start_xfer(32'h100, 32'h200, 13'd4);
    wait_idle(100, "basic");
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (peek(AW'(32'h200 + 4*i)) !== exp_w[i]) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %h required %h", i, peek(AW'(32'h200 + 4*i)), exp_w[i]);
      end
    end
    n_checks++;
    if (done_cyc - t0 + 1 !== 13 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL basic_done: latency %0d pulses %0d required 13/1", done_cyc - t0 + 1, done_cnt - d0);
    end
    n_checks++;
    if (busy_cnt - b0 !== 13) begin n_fail++; $display("FAIL basic_busy: %0d cycles required 13", busy_cnt - b0); end
    n_checks++;
    if (sts_remaining !== '0 || sts_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_status: remaining=%0d err=%b required 0/0", sts_remaining, sts_err);
    end
    n_checks++;
    if (inv_err - ie0 !== 0) begin n_fail++; $display("FAIL basic_rw_idle: %0d cycles rw=1 with access=0, required 0", inv_err - ie0); end
  endtask

  task automatic test_zero_len;
    start_xfer(32'h100, 32'h600, 13'd0);
    wait_idle(20, "zero");
    n_checks++;
    if (acc_cnt - a0 !== 0) begin n_fail++; $display("FAIL zero_access: %0d access cycles required 0", acc_cnt - a0); end
    n_checks++;
    if (done_cyc - t0 + 1 !== 1 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL zero_done: latency %0d pulses %0d required 1/1", done_cyc - t0 + 1, done_cnt - d0);
    end
    n_checks++;
    if (sts_err !== 1'b0) begin n_fail++; $display("FAIL zero_err: got %b required 0", sts_err); end
  endtask

  task automatic test_unaligned;
    poke(32'h200, 32'h0);
    start_xfer(32'h103, 32'h202, 13'd1);
    wait_idle(20, "unaligned");
    n_checks++;
    if (last_rd_addr !== 32'h100 || last_wr_addr !== 32'h200) begin
      n_fail++; $display("FAIL unaligned_addr: rd=%h wr=%h required 00000100/00000200", last_rd_addr, last_wr_addr);
    end
    n_checks++;
    if (peek(32'h200) !== 32'h11) begin n_fail++; $display("FAIL unaligned_data: got %h required 00000011", peek(32'h200)); end
  endtask

  task automatic test_stall;
    poke(32'h300, 32'hA5A5_0001);
    poke(32'h304, 32'hA5A5_0002);
    rd_stall_lim = rd_stall_seen + 5;
    wr_stall_lim = wr_stall_seen + 3;
    start_xfer(32'h300, 32'h380, 13'd2);
    wait_idle(100, "stall");
    n_checks++;
    if (peek(32'h380) !== 32'hA5A5_0001 || peek(32'h384) !== 32'hA5A5_0002) begin
      n_fail++; $display("FAIL stall_data: got %h %h required a5a50001 a5a50002", peek(32'h380), peek(32'h384));
    end
    n_checks++;
    if (done_cyc - t0 + 1 !== 15) begin n_fail++; $display("FAIL stall_done_latency: got %0d required 15", done_cyc - t0 + 1); end
    n_checks++;
    if (rd_stall_seen !== rd_stall_lim || wr_stall_seen !== wr_stall_lim || stab_err - se0 !== 0) begin
      n_fail++; $display("FAIL stall_stable: rd_stalls_left=%0d wr_stalls_left=%0d unstable=%0d required 0/0/0",
                         rd_stall_lim - rd_stall_seen, wr_stall_lim - wr_stall_seen, stab_err - se0);
    end
  endtask

  task automatic test_timeout;
    suppress_vld = 1'b1;
    start_xfer(32'h100, 32'h400, 13'd3);
    wait_idle(100, "timeout");
    suppress_vld = 1'b0;
    n_checks++;
    if (sts_err !== 1'b1 || sts_remaining !== 13'd3) begin
      n_fail++; $display("FAIL timeout_status: err=%b remaining=%0d required 1/3", sts_err, sts_remaining);
    end
    n_checks++;
    if (done_cyc - t0 + 1 !== 18 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL timeout_done: latency %0d pulses %0d required 18/1", done_cyc - t0 + 1, done_cnt - d0);
    end
    n_checks++;
    if (acc_cnt - a0 !== 1) begin n_fail++; $display("FAIL timeout_access: %0d access cycles required 1", acc_cnt - a0); end
    start_xfer(32'h0, 32'h0, 13'd0);
    wait_idle(20, "err_clear");
    n_checks++;
    if (sts_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b required 0", sts_err); end
  endtask

  task automatic test_abort;
    poke(32'h500, 32'h0);
    poke(32'h504, 32'hDEAD_BEEF);
    poke(32'h508, 32'hDEAD_BEEF);
    start_xfer(32'h100, 32'h500, 13'd5);       // cycle 1: first read
    @(posedge clk); #1;                         // cycle 2
    @(posedge clk); #1;                         // cycle 3: first write
    cfg_start = 1'b1; cfg_len = 13'd7; cfg_src_addr = 32'h300;
    @(posedge clk); #1;                         // cycle 4
    cfg_start = 1'b0;
    @(posedge clk); #1;                         // cycle 5
    @(posedge clk); #1;                         // cycle 6: second write
    n_checks++;
    if (acc !== 1'b1 || rw !== 1'b1 || addr !== 32'h504 || sts_remaining !== 13'd4) begin
      n_fail++; $display("FAIL abort_pre: acc=%b rw=%b addr=%h remaining=%0d required 1/1/00000504/4", acc, rw, addr, sts_remaining);
    end
    cfg_abort = 1'b1;
    @(posedge clk); #1;                         // cycle 7
    cfg_abort = 1'b0;
    n_checks++;
    if (sts_busy !== 1'b0 || acc !== 1'b0 || sts_remaining !== 13'd3) begin
      n_fail++; $display("FAIL abort_idle: busy=%b acc=%b remaining=%0d required 0/0/3", sts_busy, acc, sts_remaining);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 !== 0 || sts_busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: pulses %0d busy=%b required 0/0", done_cnt - d0, sts_busy);
    end
    n_checks++;
    if (peek(32'h500) !== 32'h11 || peek(32'h504) !== 32'h22 || peek(32'h508) !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL abort_data: got %h %h %h required 00000011 00000022 deadbeef",
                         peek(32'h500), peek(32'h504), peek(32'h508));
    end
  endtask

  task automatic test_reset_mid;
    start_xfer(32'h100, 32'h700, 13'd4);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (sts_busy !== 1'b0 || acc !== 1'b0 || sts_remaining !== '0 || addr !== '0) begin
      n_fail++; $display("FAIL reset_mid: busy=%b acc=%b remaining=%0d addr=%h required 0/0/0/0", sts_busy, acc, sts_remaining, addr);
    end
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_basic_copy;
    test_zero_len;
    test_unaligned;
    test_stall;
    test_timeout;
    test_abort;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtcm_dma_engine.md
Name: dtcm_dma_engine

Overview:
- DMA initiator that drives the DMA port of the data TCM (`dma_dtcm_*`); it is the requester side of that port.
- Performs forward word-by-word block copies within DTCM address space: read one source word, then write it to the destination.
- Configured by a single-cycle start command from the core/system control logic; reports busy, done, error and remaining count.

Parameters:
- ADDR_WIDTH, 32, address width; matches `ADDR_WIDTH` in top_defines.
- DATA_WIDTH, 32, data width; matches `DATA_WIDTH`.
- LEN_WIDTH, 13, word-count width; max transfer is 8191 words.
- TIMEOUT, 16, max cycles in RD_WAIT before error; must be >= 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- cfg_start  in  1  start pulse; sampled only in IDLE.
- cfg_abort  in  1  abort request; any state.
- cfg_src_addr  in  ADDR_WIDTH  source byte address; bits[1:0] ignored.
- cfg_dst_addr  in  ADDR_WIDTH  destination byte address; bits[1:0] ignored.
- cfg_len  in  LEN_WIDTH  number of 32-bit words to copy.
- sts_busy  out  1  engine not IDLE.
- sts_done  out  1  one-cycle completion pulse.
- sts_err  out  1  sticky read timeout; cleared on the next accepted start.
- sts_remaining  out  LEN_WIDTH  words not yet written.
- dma_dtcm_access  out  1  access request.
- dma_dtcm_ready  in  1  DTCM accepts the current access.
- dma_dtcm_rd0_wr1  out  1  0 = read, 1 = write.
- dma_dtcm_addr  out  ADDR_WIDTH  access byte address; bits[1:0] = 0.
- dma_dtcm_wdata  out  DATA_WIDTH  write data (full word, no strobe).
- dma_dtcm_rdata  in  DATA_WIDTH  read data.
- dma_dtcm_rdata_valid  in  1  read data valid; arrives one cycle after an accepted read.

Behaviour:
- Reset values: all outputs 0. State = IDLE; internal src/dst/count/buffer/timer registers = 0.
- States: IDLE, RD_REQ, RD_WAIT, WR, DONE. `sts_busy` = (state != IDLE).
- IDLE, on cfg_start:
  - Latch src/dst with bits[1:0] forced to 0.
  - `sts_remaining` <= cfg_len; `sts_err` <= 0.
  - If cfg_len == 0, go to DONE with no DTCM access; otherwise go to RD_REQ.
  - cfg_start outside IDLE is ignored.
- RD_REQ:
  - Drive access=1, rd0_wr1=0, addr=src.
  - On ready=1 go to RD_WAIT; otherwise hold all outputs stable.
- RD_WAIT:
  - access=0; the timer counts from 0.
  - On rdata_valid=1, capture rdata into the buffer and go to WR.
  - If the timer reaches TIMEOUT-1 without valid: `sts_err` <= 1, go to DONE. `sts_remaining` keeps its value.
- WR:
  - Drive access=1, rd0_wr1=1, addr=dst, wdata=buffer.
  - On ready=1: src += 4, dst += 4 (wrap modulo 2^ADDR_WIDTH), `sts_remaining` -= 1.
  - Then go to DONE if remaining was 1, else to RD_REQ.
- DONE: `sts_done`=1 for exactly one cycle, then IDLE.
- access is never asserted in RD_WAIT, DONE or IDLE. rd0_wr1 is 0 whenever access is 0.
- Throughput with ready=1 and valid 1 cycle after the read: 3 cycles per word. A start sampled at edge E0 gives:
  - first read in the cycle after E0;
  - done pulse 3*len+1 cycles after E0;
  - sts_busy high for 3*len+1 cycles.
- Abort (cfg_abort=1 in any non-IDLE state):
  - Next state is IDLE; no done pulse; `sts_remaining` holds.
  - A WR accepted in the same cycle as the abort commits (counters update).
  - Abort in IDLE has no effect. Abort and start together in IDLE: abort wins and the start is ignored.
- Overlapping regions: forward copy only. If dst is in (src, src+4*len), source words are overwritten before they are read; this is defined behaviour and not detected.
- Stale rdata_valid seen outside RD_WAIT is ignored.
- Reset asserted mid-transfer returns all state to reset values immediately. The in-flight DTCM write is not guaranteed.

Test Plan:
- src=0x100, dst=0x200, len=4, DTCM preloaded 0x11..0x44, ready=1 -> dst words equal 0x11,0x22,0x33,0x44; done pulse at cycle 13 after start edge; sts_remaining=0; busy for 13 cycles.
- len=0 start -> no access asserted; done pulse in the cycle after start; sts_err=0.
- src=0x103, dst=0x202, len=1 -> read addr 0x100, write addr 0x200.
- ready held low 5 cycles in RD_REQ and 3 cycles in WR, len=2 -> addr/rd0_wr1 stable while ready=0; data correct; done 8 cycles later than nominal.
- rdata_valid suppressed, TIMEOUT=16, len=3 -> sts_err=1 after 16 RD_WAIT cycles; done pulse; sts_remaining=3; next start clears sts_err.
- abort at the 2nd WR cycle of len=5 with ready=1 -> that write commits; IDLE next cycle; no done pulse; sts_remaining=3; a start issued during busy has no effect.
